// File: rtl/grant_service_if.sv
// Grant/service handshake bundle between the arbiter side and the controller.
// The slave modport is the controller; the master modport drives grants.
interface grant_service_if #(
    parameter int CW = 8
);
    logic [3:0]      grant_i;
    logic            done_i;
    logic            start_o;
    logic            busy_o;
    logic [1:0]      user_o;
    logic            timeout_o;
    logic            err_o;
    logic [4*CW-1:0] serve_cnt_o;

    modport slave (
        input  grant_i,
        input  done_i,
        output start_o,
        output busy_o,
        output user_o,
        output timeout_o,
        output err_o,
        output serve_cnt_o
    );

    modport master (
        output grant_i,
        output done_i,
        input  start_o,
        input  busy_o,
        input  user_o,
        input  timeout_o,
        input  err_o,
        input  serve_cnt_o
    );
endinterface

// File: rtl/grant_service_ctrl.sv
// Grant-driven service controller: launches one transaction per new grant,
// tracks done/timeout, applies cooldown, counts completed services per user.
module grant_service_ctrl #(
    parameter int TIMEOUT = 15,
    parameter int COOL    = 1,
    parameter int CW      = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    grant_service_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SERVE = 2'd1,
        S_COOL  = 2'd2
    } state_t;

    localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);
    localparam logic [3:0] CLOAD = 4'(COOL - 1);

    state_t        state_q;
    logic [1:0]    user_q;
    logic          start_q;
    logic          busy_q;
    logic          timeout_q;
    logic [7:0]    timer_q;
    logic [3:0]    cool_q;

    logic [3:0]    prev_q, prev_d;
    logic          err_q, err_d;
    logic          pend_v_q, pend_v_d;
    logic [1:0]    pend_u_q, pend_u_d;
    logic [CW-1:0] cnt_q [4];
    logic [CW-1:0] cnt_d [4];

    logic          legal;
    logic          nonzero;
    logic [1:0]    g_idx;
    logic          new_grant;
    logic          launch;
    logic [1:0]    launch_u;
    logic          serve_done;

    // Decode the grant sample: legality, one-hot index, newness.
    always_comb begin
        legal   = 1'b1;
        nonzero = 1'b1;
        g_idx   = 2'd0;
        unique case (bus.grant_i)
            4'b0000: nonzero = 1'b0;
            4'b1000: g_idx   = 2'd0;
            4'b0100: g_idx   = 2'd1;
            4'b0010: g_idx   = 2'd2;
            4'b0001: g_idx   = 2'd3;
            default: begin
                legal   = 1'b0;
                nonzero = 1'b0;
            end
        endcase
        new_grant = legal && nonzero && (bus.grant_i != prev_q);
    end

    // A fresh grant takes priority over the pending slot when launching.
    always_comb begin
        launch     = (state_q == S_IDLE) && (new_grant || pend_v_q);
        launch_u   = new_grant ? g_idx : pend_u_q;
        serve_done = (state_q == S_SERVE) && bus.done_i;
    end

    // Next values for grant history, error flag and the pending slot.
    always_comb begin
        prev_d   = legal ? bus.grant_i : prev_q;
        err_d    = !legal;
        pend_v_d = pend_v_q;
        pend_u_d = pend_u_q;
        if (launch) begin
            pend_v_d = 1'b0;
        end else if (new_grant) begin
            pend_v_d = 1'b1;
            pend_u_d = g_idx;
        end
    end

    // Saturating per-user completion counters.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = cnt_q[i];
            if (serve_done && (user_q == 2'(i)) && (cnt_q[i] != '1)) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    // Grant history, illegal-sample flag and pending slot registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q   <= 4'd0;
            err_q    <= 1'b0;
            pend_v_q <= 1'b0;
            pend_u_q <= 2'd0;
        end else begin
            prev_q   <= prev_d;
            err_q    <= err_d;
            pend_v_q <= pend_v_d;
            pend_u_q <= pend_u_d;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Service FSM with registered start/busy/timeout/user outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            user_q    <= 2'd0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            timer_q   <= 8'd0;
            cool_q    <= 4'd0;
        end else begin
            start_q   <= 1'b0;
            timeout_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (launch) begin
                        state_q <= S_SERVE;
                        user_q  <= launch_u;
                        timer_q <= 8'd0;
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                S_SERVE: begin
                    if (bus.done_i) begin
                        state_q <= S_COOL;
                        cool_q  <= CLOAD;
                    end else if (timer_q == TLAST) begin
                        state_q   <= S_COOL;
                        cool_q    <= CLOAD;
                        timeout_q <= 1'b1;
                    end else begin
                        timer_q <= timer_q + 8'd1;
                    end
                end
                S_COOL: begin
                    if (cool_q == 4'd0) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cool_q <= cool_q - 4'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Drive the bundle outputs from registers.
    always_comb begin
        bus.start_o   = start_q;
        bus.busy_o    = busy_q;
        bus.user_o    = user_q;
        bus.timeout_o = timeout_q;
        bus.err_o     = err_q;
        for (int i = 0; i < 4; i++) begin
            bus.serve_cnt_o[i*CW +: CW] = cnt_q[i];
        end
    end
endmodule

// File: tb/tb_grant_service_ctrl.sv
// Directed bench for grant_service_ctrl: vector table plus
// hand sequences for pending overwrite, reset abort, saturation.
module tb_grant_service_ctrl;
    localparam int CW = 8;
    localparam int NV = 24;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    grant_service_if #(.CW(CW)) bus ();

    grant_service_ctrl #(
        .TIMEOUT(15),
        .COOL(1),
        .CW(CW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  g;
        logic        d;
        logic [5:0]  ctl;
        logic [31:0] cnt;
    } vec_t;

    vec_t tbl [NV];

    function automatic logic [5:0] mk(input logic s, input logic b,
                                      input logic [1:0] u, input logic t,
                                      input logic e);
        return {s, b, u, t, e};
    endfunction

    function automatic logic [5:0] ctl_now();
        return {bus.start_o, bus.busy_o, bus.user_o, bus.timeout_o, bus.err_o};
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        do begin
            tick();
            n++;
        end while (bus.busy_o && n < 20);
        check(name, 32'(bus.busy_o), 32'd0);
    endtask

    initial begin
        int starts;
        logic [1:0] su;
        logic to_seen;

        // Row layout: inputs for one cycle, expected outputs after the edge.
        tbl[0]  = '{4'b1000, 1'b0, mk(1, 1, 0, 0, 0), 32'h0};
        tbl[1]  = '{4'b1000, 1'b0, mk(0, 1, 0, 0, 0), 32'h0};
        tbl[2]  = '{4'b1000, 1'b0, mk(0, 1, 0, 0, 0), 32'h0};
        tbl[3]  = '{4'b1000, 1'b1, mk(0, 1, 0, 0, 0), 32'h1};
        tbl[4]  = '{4'b1000, 1'b0, mk(0, 0, 0, 0, 0), 32'h1};
        tbl[5]  = '{4'b0000, 1'b0, mk(0, 0, 0, 0, 0), 32'h1};
        tbl[6]  = '{4'b0110, 1'b0, mk(0, 0, 0, 0, 1), 32'h1};
        tbl[7]  = '{4'b0100, 1'b0, mk(1, 1, 1, 0, 0), 32'h1};
        for (int i = 8; i < 22; i++) begin
            tbl[i] = '{4'b0100, 1'b0, mk(0, 1, 1, 0, 0), 32'h1};
        end
        tbl[22] = '{4'b0100, 1'b0, mk(0, 1, 1, 1, 0), 32'h1};
        tbl[23] = '{4'b0100, 1'b0, mk(0, 0, 1, 0, 0), 32'h1};

        bus.grant_i = 4'b0000;
        bus.done_i  = 1'b0;
        #12;
        check("reset_ctl", 32'(ctl_now()), 32'd0);
        check("reset_cnt", bus.serve_cnt_o, 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < NV; i++) begin
            bus.grant_i = tbl[i].g;
            bus.done_i  = tbl[i].d;
            tick();
            check($sformatf("row%0d_ctl", i), 32'(ctl_now()), 32'(tbl[i].ctl));
            check($sformatf("row%0d_cnt", i), bus.serve_cnt_o, tbl[i].cnt);
        end

        // Two grants during SERVE: only the latest (user3) is served next.
        bus.grant_i = 4'b1000;
        tick();
        check("ovr_start0", 32'(ctl_now()), 32'(mk(1, 1, 0, 0, 0)));
        bus.grant_i = 4'b0010;
        tick();
        bus.grant_i = 4'b0001;
        tick();
        bus.done_i = 1'b1;
        tick();
        bus.done_i = 1'b0;
        starts = 0;
        su = 2'd0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.start_o) begin
                starts++;
                su = bus.user_o;
            end
        end
        check("ovr_starts", 32'(starts), 32'd1);
        check("ovr_user", 32'(su), 32'd3);
        bus.done_i = 1'b1;
        tick();
        bus.done_i = 1'b0;
        wait_idle("ovr_idle");
        check("ovr_cnt", bus.serve_cnt_o, 32'h0100_0002);

        // Reset in mid-SERVE aborts; held grant restarts after release.
        bus.grant_i = 4'b1000;
        tick();
        check("rst_pre_start", 32'(bus.start_o), 32'd1);
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_ctl", 32'(ctl_now()), 32'd0);
        check("rst_cnt", bus.serve_cnt_o, 32'd0);
        #2;
        rst_n = 1'b1;
        tick();
        check("rst_restart", 32'(ctl_now()), 32'(mk(1, 1, 0, 0, 0)));
        bus.done_i = 1'b1;
        tick();
        bus.done_i = 1'b0;
        wait_idle("rst_idle");
        check("rst_cnt_after", bus.serve_cnt_o, 32'h1);

        // Saturate user3 with 256 one-cycle services.
        bus.grant_i = 4'b0000;
        tick();
        to_seen = 1'b0;
        for (int k = 1; k <= 256; k++) begin
            bus.grant_i = 4'b0001;
            bus.done_i  = 1'b0;
            tick();
            bus.grant_i = 4'b0000;
            bus.done_i  = 1'b1;
            tick();
            if (bus.timeout_o) to_seen = 1'b1;
            bus.done_i = 1'b0;
            wait_idle($sformatf("sat_idle%0d", k));
            if (k == 255) check("sat_255", bus.serve_cnt_o, 32'hFF00_0001);
        end
        check("sat_hold", bus.serve_cnt_o, 32'hFF00_0001);
        check("sat_no_to", 32'(to_seen), 32'd0);

        // done_i on the final SERVE cycle wins over the timeout.
        bus.grant_i = 4'b0010;
        tick();
        check("tie_start", 32'(ctl_now()), 32'(mk(1, 1, 2, 0, 0)));
        to_seen = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (bus.timeout_o || !bus.busy_o) to_seen = 1'b1;
        end
        check("tie_early", 32'(to_seen), 32'd0);
        bus.done_i = 1'b1;
        tick();
        bus.done_i = 1'b0;
        check("tie_ctl", 32'(ctl_now()), 32'(mk(0, 1, 2, 0, 0)));
        check("tie_cnt", bus.serve_cnt_o, 32'hFF01_0001);
        wait_idle("tie_idle");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
